// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
// Carries the hazard inputs from ID/EX/MEM and the stall/flush controls sent back.
interface hazard_ctrl_if;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       id_use_rs1;
   logic       id_use_rs2;
   logic       ex_memread;
   logic [4:0] ex_rd;
   logic       branch_taken;
   logic       dmem_busy;
   logic       pc_write;
   logic       ifid_stall;
   logic       ifid_flush;
   logic       idex_bubble;
   logic       pipe_freeze;

   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memread, ex_rd, branch_taken, dmem_busy,
      input  pc_write, ifid_stall, ifid_flush, idex_bubble, pipe_freeze
   );

   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memread, ex_rd, branch_taken, dmem_busy,
      output pc_write, ifid_stall, ifid_flush, idex_bubble, pipe_freeze
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use stalls, taken-branch squashes and
// data-memory freezes, plus saturating stall/flush performance counters.
module hazard_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   hazard_ctrl_if.slave     hz,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      FLUSH      = 2'd2,
      MEM_WAIT   = 2'd3
   } state_t;

   localparam logic [2:0]       FLUSH_RELOAD = 3'(FLUSH_CYCLES - 32'd1);
   localparam state_t           BRANCH_NEXT  = (FLUSH_CYCLES > 32'd1) ? FLUSH : RUN;
   localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_r;
   state_t           state_nxt_s;
   logic [2:0]       fcnt_r;
   logic [2:0]       fcnt_nxt_s;
   logic             load_use_s;
   logic             lu_armed_s;
   logic             pc_write_s;
   logic             stall_s;
   logic             flush_s;
   logic             bubble_s;
   logic             freeze_s;
   logic             branch_ev_s;
   logic [CNT_W-1:0] stall_cnt_r;
   logic [CNT_W-1:0] flush_cnt_r;

   // The load leaves EX once stalled, so LOAD_STALL and FLUSH never re-detect load-use.
   assign load_use_s = hz.ex_memread && (hz.ex_rd != 5'd0) &&
                       ((hz.id_use_rs1 && (hz.ex_rd == hz.id_rs1)) ||
                        (hz.id_use_rs2 && (hz.ex_rd == hz.id_rs2)));
   assign lu_armed_s = (state_r == RUN) || (state_r == MEM_WAIT);

   // State register and flush-window down-counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= RUN;
         fcnt_r  <= 3'd0;
      end else begin
         state_r <= state_nxt_s;
         fcnt_r  <= fcnt_nxt_s;
      end
   end

   // Next-state logic; a released MEM_WAIT is evaluated exactly like RUN.
   always_comb begin
      state_nxt_s = state_r;
      fcnt_nxt_s  = fcnt_r;
      if (hz.dmem_busy) begin
         state_nxt_s = MEM_WAIT;
         fcnt_nxt_s  = 3'd0;
      end else if (hz.branch_taken) begin
         state_nxt_s = BRANCH_NEXT;
         fcnt_nxt_s  = FLUSH_RELOAD;
      end else begin
         case (state_r)
            FLUSH: begin
               if (fcnt_r <= 3'd1) begin
                  state_nxt_s = RUN;
                  fcnt_nxt_s  = 3'd0;
               end else begin
                  fcnt_nxt_s = fcnt_r - 3'd1;
               end
            end
            RUN, MEM_WAIT: begin
               if (load_use_s) begin
                  state_nxt_s = LOAD_STALL;
               end else begin
                  state_nxt_s = RUN;
               end
            end
            LOAD_STALL: state_nxt_s = RUN;
            default: begin
               state_nxt_s = RUN;
               fcnt_nxt_s  = 3'd0;
            end
         endcase
      end
   end

   // Pipeline controls, acted on in the same cycle the hazard appears.
   always_comb begin
      pc_write_s  = 1'b1;
      stall_s     = 1'b0;
      flush_s     = 1'b0;
      bubble_s    = 1'b0;
      freeze_s    = 1'b0;
      branch_ev_s = 1'b0;
      if (reset) begin
         pc_write_s = 1'b0;
         flush_s    = 1'b1;
         bubble_s   = 1'b1;
      end else if (hz.dmem_busy) begin
         freeze_s   = 1'b1;
         pc_write_s = 1'b0;
         stall_s    = 1'b1;
      end else if (hz.branch_taken) begin
         flush_s     = 1'b1;
         bubble_s    = 1'b1;
         branch_ev_s = 1'b1;
      end else if (state_r == FLUSH) begin
         flush_s  = 1'b1;
         bubble_s = 1'b1;
      end else if (load_use_s && lu_armed_s) begin
         pc_write_s = 1'b0;
         stall_s    = 1'b1;
         bubble_s   = 1'b1;
      end else begin
         pc_write_s = 1'b1;
      end
   end

   assign hz.pc_write    = pc_write_s;
   assign hz.ifid_stall  = stall_s & ~flush_s;
   assign hz.ifid_flush  = flush_s;
   assign hz.idex_bubble = bubble_s;
   assign hz.pipe_freeze = freeze_s;

   // Saturating performance counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_r <= {CNT_W{1'b0}};
         flush_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (!pc_write_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
         if (branch_ev_s && (flush_cnt_r != CNT_MAX)) begin
            flush_cnt_r <= flush_cnt_r + CNT_ONE;
         end else begin
            flush_cnt_r <= flush_cnt_r;
         end
      end
   end

   assign stall_cnt = stall_cnt_r;
   assign flush_cnt = flush_cnt_r;
endmodule
